mux_n_reg: RTL and testbench

- N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake; successor to the 4:1 16-bit combinational operand mux.
- Two selection modes, chosen at run time:
  - explicit select (S), the legacy behaviour;
  - round-robin arbitration among valid channels.
- One-entry output register toward a single downstream consumer, plus a wrapping transfer counter.
- Used in the 16-bit datapath where several producers share one bus.

---
 rtl/mux_n_reg.sv | 101 ++++++++++
 tb/tb_mux_n_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_reg.sv
// N-channel registered multiplexer with valid/ready handshake, selectable
// explicit-select or round-robin arbitration, and a wrapping transfer counter.
module mux_n_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SW    = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               MODE,
    input  logic [SW-1:0]      S,
    input  logic [N*WIDTH-1:0] D_IN,
    input  logic [N-1:0]       V_IN,
    output logic [N-1:0]       RDY_OUT,
    output logic [WIDTH-1:0]   R,
    output logic               R_V,
    input  logic               R_RDY,
    output logic [SW-1:0]      R_CH,
    output logic [15:0]        COUNT
);

    logic [WIDTH-1:0] r_data;
    logic             r_v;
    logic [SW-1:0]    r_ch;
    logic [SW-1:0]    r_ptr;
    logic [15:0]      r_count;

    logic             w_load;
    logic             w_found;
    logic [SW-1:0]    w_gidx;
    logic [WIDTH-1:0] w_data;

    assign w_load = !r_v || R_RDY;

    // Grant search; in round-robin the k loop runs backwards so the nearest
    // valid channel after PTR is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        if (!MODE) begin
            for (int i = 0; i < N; i++) begin
                if (SW'(i) == S && V_IN[i]) begin
                    w_found = 1'b1;
                    w_gidx  = SW'(i);
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (V_IN[i] && ((int'(r_ptr) + k) % N) == i) begin
                        w_found = 1'b1;
                        w_gidx  = SW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == w_gidx) w_data = D_IN[i*WIDTH +: WIDTH];
        end
    end

    // RST_N gating keeps RDY_OUT low during reset even though load is true then.
    always_comb begin
        RDY_OUT = '0;
        for (int i = 0; i < N; i++) begin
            if (RST_N && w_load && w_found && SW'(i) == w_gidx) RDY_OUT[i] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data  <= '0;
            r_v     <= 1'b0;
            r_ch    <= '0;
            r_ptr   <= SW'(N - 1);
            r_count <= '0;
        end else begin
            if (w_load) begin
                if (w_found) begin
                    r_data <= w_data;
                    r_ch   <= w_gidx;
                    r_v    <= 1'b1;
                    if (MODE) r_ptr <= w_gidx;
                end else begin
                    r_v <= 1'b0;
                end
            end
            if (r_v && R_RDY) r_count <= r_count + 16'd1;
        end
    end

    assign R     = r_data;
    assign R_V   = r_v;
    assign R_CH  = r_ch;
    assign COUNT = r_count;

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: stimulus pushes expected {data, channel},
// a negedge monitor pops and compares on every accepted output word.
module tb_mux_n_reg;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MODE;
    logic [1:0]  S;
    logic [63:0] D_IN;
    logic [3:0]  V_IN;
    logic [3:0]  RDY_OUT;
    logic [15:0] R;
    logic        R_V;
    logic        R_RDY;
    logic [1:0]  R_CH;
    logic [15:0] COUNT;

    logic [2:0]  RDY_OUT3;
    logic [15:0] R3;
    logic        R_V3;
    logic [1:0]  R_CH3;
    logic [15:0] COUNT3;

    int n_total = 0;
    int n_pass  = 0;
    logic [17:0] sb[$];
    logic [15:0] chan_val [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    always #5 CLK = ~CLK;

    mux_n_reg #(.WIDTH(16), .N(4), .SW(2)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .S(S), .D_IN(D_IN), .V_IN(V_IN),
        .RDY_OUT(RDY_OUT), .R(R), .R_V(R_V), .R_RDY(R_RDY), .R_CH(R_CH), .COUNT(COUNT)
    );

    mux_n_reg #(.WIDTH(16), .N(3), .SW(2)) u_dut3 (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .S(S), .D_IN(D_IN[47:0]), .V_IN(V_IN[2:0]),
        .RDY_OUT(RDY_OUT3), .R(R3), .R_V(R_V3), .R_RDY(1'b1), .R_CH(R_CH3), .COUNT(COUNT3)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Monitor: every accepted output word must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N && R_V && R_RDY) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {R, R_CH}, 32'hFFFF_FFFF);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                chk("word_data", 32'(R), 32'(e[17:2]));
                chk("word_ch", 32'(R_CH), 32'(e[1:0]));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expect a grant on ch this cycle, record the word it must produce, advance.
    task automatic issue(input int ch, input string name);
        #1;
        chk(name, 32'(RDY_OUT), 32'(1) << ch);
        sb.push_back({chan_val[ch], 2'(ch)});
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0; MODE = 1'b0; S = 2'd0; V_IN = 4'b0000; R_RDY = 1'b0;
        D_IN = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        step(); step();
        chk("rst_R", 32'(R), 32'h0);
        chk("rst_RV", 32'(R_V), 32'h0);
        chk("rst_RCH", 32'(R_CH), 32'h0);
        chk("rst_COUNT", 32'(COUNT), 32'h0);
        chk("rst_RDY", 32'(RDY_OUT), 32'h0);
        RST_N = 1'b1;

        // Select sweep
        V_IN = 4'b1111; R_RDY = 1'b1;
        for (int s = 0; s < 4; s++) begin
            S = 2'(s);
            issue(s, "sweep_rdy");
        end
        V_IN = 4'b0000;
        #1 chk("sweep_norequest_rdy", 32'(RDY_OUT), 32'h0);
        step();
        chk("sweep_count", 32'(COUNT), 32'd4);
        chk("sweep_rv_low", 32'(R_V), 32'h0);
        chk("sweep_r_hold", 32'(R), 32'h4444);

        // Backpressure
        V_IN = 4'b1111; S = 2'd1;
        issue(1, "bp_load_rdy");
        R_RDY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            S = 2'(c + 2);
            D_IN = {16'hDEAD, 16'hBEEF, 16'(16'hA5A0 + c), 16'h0F0F};
            #1;
            chk("bp_rdy", 32'(RDY_OUT), 32'h0);
            chk("bp_R", 32'(R), 32'h2222);
            chk("bp_RV", 32'(R_V), 32'h1);
            chk("bp_count", 32'(COUNT), 32'd4);
            step();
        end
        D_IN = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        S = 2'd3; R_RDY = 1'b1;
        issue(3, "bp_release_rdy");
        chk("bp_new_R", 32'(R), 32'h4444);
        chk("bp_new_RCH", 32'(R_CH), 32'd3);
        chk("bp_count5", 32'(COUNT), 32'd5);

        // Asynchronous reset while holding a word
        MODE = 1'b1; V_IN = 4'b1111;
        #1 RST_N = 1'b0;
        #1;
        sb.delete();
        chk("async_R", 32'(R), 32'h0);
        chk("async_RV", 32'(R_V), 32'h0);
        chk("async_RCH", 32'(R_CH), 32'h0);
        chk("async_COUNT", 32'(COUNT), 32'h0);
        chk("async_RDY", 32'(RDY_OUT), 32'h0);
        step();
        RST_N = 1'b1;

        // Round-robin fairness, first grant after reset is channel 0
        issue(0, "rr_first_ch0");
        issue(1, "rr_all");
        issue(2, "rr_all");
        issue(3, "rr_all");
        issue(0, "rr_all_wrap");
        V_IN = 4'b1010;
        issue(1, "rr_1010");
        issue(3, "rr_1010");
        issue(1, "rr_1010");
        issue(3, "rr_1010");
        V_IN = 4'b0000;
        #1 chk("rr_idle_rdy", 32'(RDY_OUT), 32'h0);
        step();
        chk("rr_rv_low", 32'(R_V), 32'h0);
        chk("rr_rch_hold", 32'(R_CH), 32'd3);
        chk("rr_count", 32'(COUNT), 32'd9);

        // No-grant select
        MODE = 1'b0; S = 2'd0; V_IN = 4'b1011;
        issue(0, "ng_load_rdy");
        S = 2'd2;
        #1 chk("ng_rdy", 32'(RDY_OUT), 32'h0);
        step();
        chk("ng_rv_low", 32'(R_V), 32'h0);
        chk("ng_r_hold", 32'(R), 32'h1111);
        chk("ng_count", 32'(COUNT), 32'd10);
        V_IN = 4'b1111; S = 2'd3;
        #1;
        chk("n3_s3_rdy", 32'(RDY_OUT3), 32'h0);
        chk("n4_s3_rdy", 32'(RDY_OUT), 32'h8);
        S = 2'd2;
        #1 chk("n3_s2_rdy", 32'(RDY_OUT3), 32'h4);
        V_IN = 4'b0000;
        step();

        // Counter wrap
        S = 2'd0; V_IN = 4'b0001;
        for (int i = 0; i < 65524; i++) begin
            sb.push_back({16'h1111, 2'd0});
            step();
        end
        V_IN = 4'b0000;
        step();
        chk("wrap_fffe", 32'(COUNT), 32'hFFFE);
        V_IN = 4'b0001;
        issue(0, "wrap_rdy");
        V_IN = 4'b0000;
        step();
        chk("wrap_ffff", 32'(COUNT), 32'hFFFF);
        V_IN = 4'b0001;
        issue(0, "wrap_rdy");
        V_IN = 4'b0000;
        step();
        chk("wrap_zero", 32'(COUNT), 32'h0);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
